// File: rtl/sram_rw_arbiter_if.sv
// Bus bundle between the frame-buffer arbiter, its two requesters and the SRAM pins.
interface sram_rw_arbiter_if #(
    parameter int unsigned ADDRESSSIZE = 15,
    parameter int unsigned WORDSIZE    = 64
);
    localparam int unsigned CA_W = 4;
    localparam int unsigned RA_W = ADDRESSSIZE - CA_W;

    // write requester
    logic                   iWrValid;
    logic [ADDRESSSIZE-1:0] iWrAddr;
    logic [WORDSIZE-1:0]    iWrData;
    logic                   oWrReady;

    // read requester
    logic                   iRdValid;
    logic [ADDRESSSIZE-1:0] iRdAddr;
    logic                   oRdReady;
    logic                   oRdDataValid;
    logic [WORDSIZE-1:0]    oRdData;

    // SRAM pins
    logic                   oNCE;
    logic                   oNWRT;
    logic [RA_W-1:0]        oRA;
    logic [CA_W-1:0]        oCA;
    logic [WORDSIZE-1:0]    oDIN;
    logic [WORDSIZE-1:0]    iDO;

    // arbiter side
    modport slave (
        input  iWrValid, iWrAddr, iWrData,
        output oWrReady,
        input  iRdValid, iRdAddr,
        output oRdReady, oRdDataValid, oRdData,
        output oNCE, oNWRT, oRA, oCA, oDIN,
        input  iDO
    );

    // requesters plus SRAM side
    modport master (
        output iWrValid, iWrAddr, iWrData,
        input  oWrReady,
        output iRdValid, iRdAddr,
        input  oRdReady, oRdDataValid, oRdData,
        input  oNCE, oNWRT, oRA, oCA, oDIN,
        output iDO
    );
endinterface

// File: rtl/sram_rw_arbiter.sv
// Round-robin bounded-burst arbiter sharing one single-port frame-buffer SRAM
// between a write stream and a read stream; registered SRAM pins, fixed read latency.
module sram_rw_arbiter #(
    parameter int unsigned ADDRESSSIZE = 15,
    parameter int unsigned WORDSIZE    = 64,
    parameter int unsigned BURST_LEN   = 16
) (
    input  logic               iClk,
    input  logic               iReset,
    sram_rw_arbiter_if.slave   bus
);
    localparam int unsigned CA_W  = 4;
    localparam int unsigned RA_W  = ADDRESSSIZE - CA_W;
    localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 last_wr_q, last_wr_d;   // 1: write side was served last

    logic                 nce_q, nce_d;
    logic                 nwrt_q, nwrt_d;
    logic [RA_W-1:0]      ra_q, ra_d;
    logic [CA_W-1:0]      ca_q, ca_d;
    logic [WORDSIZE-1:0]  din_q, din_d;

    logic                 rd_issue_q, rd_issue_d; // read op on the pins this cycle
    logic                 rd_wait_q, rd_wait_d;   // iDO carries read data this cycle
    logic                 rd_vld_q, rd_vld_d;
    logic [WORDSIZE-1:0]  rd_data_q, rd_data_d;

    logic                 wr_acc_c;
    logic                 rd_acc_c;

    assign wr_acc_c = bus.iWrValid && (state_q == ST_WR);
    assign rd_acc_c = bus.iRdValid && (state_q == ST_RD);

    // Grant selection and burst accounting
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_wr_d = last_wr_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.iWrValid && bus.iRdValid) begin
                    state_d = last_wr_q ? ST_RD : ST_WR;
                end else if (bus.iWrValid) begin
                    state_d = ST_WR;
                end else if (bus.iRdValid) begin
                    state_d = ST_RD;
                end
            end
            ST_WR: begin
                if (!bus.iWrValid || ((cnt_q == LAST_BEAT) && bus.iRdValid)) begin
                    cnt_d = '0;
                    if (bus.iRdValid) begin
                        state_d   = ST_RD;
                        last_wr_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    // uncontended: keep the grant and restart the count at the limit
                    cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
                end
            end
            ST_RD: begin
                if (!bus.iRdValid || ((cnt_q == LAST_BEAT) && bus.iWrValid)) begin
                    cnt_d = '0;
                    if (bus.iWrValid) begin
                        state_d   = ST_WR;
                        last_wr_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // SRAM pin drive and read-return pipeline
    always_comb begin
        nce_d      = 1'b1;
        nwrt_d     = 1'b1;
        ra_d       = ra_q;
        ca_d       = ca_q;
        din_d      = din_q;
        if (wr_acc_c) begin
            nce_d  = 1'b0;
            nwrt_d = 1'b0;
            ra_d   = bus.iWrAddr[ADDRESSSIZE-1:CA_W];
            ca_d   = bus.iWrAddr[CA_W-1:0];
            din_d  = bus.iWrData;
        end else if (rd_acc_c) begin
            nce_d  = 1'b0;
            ra_d   = bus.iRdAddr[ADDRESSSIZE-1:CA_W];
            ca_d   = bus.iRdAddr[CA_W-1:0];
        end
        rd_issue_d = rd_acc_c;
        rd_wait_d  = rd_issue_q;
        rd_vld_d   = rd_wait_q;
        rd_data_d  = rd_wait_q ? bus.iDO : rd_data_q;
    end

    // State and output registers
    always_ff @(posedge iClk) begin
        if (!iReset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_wr_q  <= 1'b0;
            nce_q      <= 1'b1;
            nwrt_q     <= 1'b1;
            ra_q       <= '0;
            ca_q       <= '0;
            din_q      <= '0;
            rd_issue_q <= 1'b0;
            rd_wait_q  <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_wr_q  <= last_wr_d;
            nce_q      <= nce_d;
            nwrt_q     <= nwrt_d;
            ra_q       <= ra_d;
            ca_q       <= ca_d;
            din_q      <= din_d;
            rd_issue_q <= rd_issue_d;
            rd_wait_q  <= rd_wait_d;
            rd_vld_q   <= rd_vld_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.oWrReady     = (state_q == ST_WR);
    assign bus.oRdReady     = (state_q == ST_RD);
    assign bus.oNCE         = nce_q;
    assign bus.oNWRT        = nwrt_q;
    assign bus.oRA          = ra_q;
    assign bus.oCA          = ca_q;
    assign bus.oDIN         = din_q;
    assign bus.oRdDataValid = rd_vld_q;
    assign bus.oRdData      = rd_data_q;
endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Self-checking bench for sram_rw_arbiter: SRAM model, read-data scoreboard, per-scenario tasks.
module tb_sram_rw_arbiter;
    localparam int unsigned AW = 15;
    localparam int unsigned DW = 64;
    localparam int unsigned BL = 16;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rd_exp_t;

    logic    iClk = 1'b0;
    logic    iReset = 1'b0;
    int      checks = 0;
    int      failures = 0;
    int      cyc = 0;
    int      rd_seen = 0;

    rd_exp_t        rd_q[$];
    logic [DW-1:0]  rd_log[$];
    logic [DW-1:0]  shadow [0:32767];
    logic [DW-1:0]  sram_mem [0:32767];
    logic [80:0]    exp_pins = {1'b1, 1'b1, 11'd0, 4'd0, 64'd0};
    logic [DW-1:0]  hold_data = '0;

    sram_rw_arbiter_if #(.ADDRESSSIZE(AW), .WORDSIZE(DW)) bus ();

    sram_rw_arbiter #(.ADDRESSSIZE(AW), .WORDSIZE(DW), .BURST_LEN(BL)) dut (
        .iClk   (iClk),
        .iReset (iReset),
        .bus    (bus)
    );

    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;

    // SRAM model: data appears on iDO the cycle after the read edge
    initial begin
        bus.iDO = '0;
        forever begin
            @(posedge iClk);
            if (bus.oNCE === 1'b0) begin
                if (bus.oNWRT === 1'b0) sram_mem[{bus.oRA, bus.oCA}] = bus.oDIN;
                else bus.iDO <= sram_mem[{bus.oRA, bus.oCA}];
            end
        end
    end

    // Monitor: pin expectations from accepted beats, read-data scoreboard
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge iClk);
            checks++;
            if ({bus.oNCE, bus.oNWRT, bus.oRA, bus.oCA, bus.oDIN} !== exp_pins) begin
                failures++;
                $display("FAIL sram_pins cyc=%0d got=%h exp=%h", cyc,
                         {bus.oNCE, bus.oNWRT, bus.oRA, bus.oCA, bus.oDIN}, exp_pins);
            end
            checks++;
            if (bus.oWrReady === 1'b1 && bus.oRdReady === 1'b1) begin
                failures++;
                $display("FAIL both_ready cyc=%0d got=11 exp=not both", cyc);
            end
            if (bus.oRdDataValid === 1'b1) begin
                checks++;
                if (rd_q.size() == 0) begin
                    failures++;
                    $display("FAIL rd_unexpected cyc=%0d got=%h exp=no valid", cyc, bus.oRdData);
                end else begin
                    e = rd_q.pop_front();
                    if (bus.oRdData !== e.data || cyc != e.due) begin
                        failures++;
                        $display("FAIL rd_data cyc=%0d got=%h exp=%h due=%0d", cyc, bus.oRdData, e.data, e.due);
                    end
                end
                rd_seen++;
                rd_log.push_back(bus.oRdData);
                hold_data = bus.oRdData;
            end else begin
                checks++;
                if (bus.oRdData !== hold_data) begin
                    failures++;
                    $display("FAIL rd_hold cyc=%0d got=%h exp=%h", cyc, bus.oRdData, hold_data);
                end
                if (rd_q.size() != 0) begin
                    checks++;
                    if (rd_q[0].due <= cyc) begin
                        failures++;
                        $display("FAIL rd_missing cyc=%0d got=none exp=%h", cyc, rd_q[0].data);
                        void'(rd_q.pop_front());
                    end
                end
            end
            // expectation for the next cycle
            if (iReset === 1'b0) begin
                exp_pins  = {1'b1, 1'b1, 11'd0, 4'd0, 64'd0};
                hold_data = '0;
                rd_q.delete();
            end else if (bus.iWrValid === 1'b1 && bus.oWrReady === 1'b1) begin
                shadow[bus.iWrAddr] = bus.iWrData;
                exp_pins = {1'b0, 1'b0, bus.iWrAddr, bus.iWrData};
            end else if (bus.iRdValid === 1'b1 && bus.oRdReady === 1'b1) begin
                rd_q.push_back('{data: shadow[bus.iRdAddr], due: cyc + 3});
                exp_pins = {1'b0, 1'b1, bus.iRdAddr, exp_pins[63:0]};
            end else begin
                exp_pins[80:79] = 2'b11;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.iWrValid = 1'b0;
        bus.iRdValid = 1'b0;
        bus.iWrAddr  = '0;
        bus.iWrData  = '0;
        bus.iRdAddr  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        iReset = 1'b0;
        repeat (2) begin @(posedge iClk); #1; end
        iReset = 1'b1;
    endtask

    task automatic wr_beat(input logic [AW-1:0] a, input logic [DW-1:0] d, output int acc, output bit ok);
        bus.iWrValid = 1'b1;
        bus.iWrAddr  = a;
        bus.iWrData  = d;
        ok  = 1'b0;
        acc = -1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge iClk);
            if (bus.oWrReady === 1'b1) begin ok = 1'b1; acc = cyc; end
            @(posedge iClk); #1;
        end
    endtask

    task automatic rd_beat(input logic [AW-1:0] a, output int acc, output bit ok);
        bus.iRdValid = 1'b1;
        bus.iRdAddr  = a;
        ok  = 1'b0;
        acc = -1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge iClk);
            if (bus.oRdReady === 1'b1) begin ok = 1'b1; acc = cyc; end
            @(posedge iClk); #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && rd_q.size() != 0; i++) @(negedge iClk);
        checks++;
        if (rd_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending exp=0", rd_q.size());
        end
        @(posedge iClk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        iReset = 1'b0;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        checks++; if (bus.oNCE !== 1'b1) begin failures++; $display("FAIL rst_nce got=%b exp=1", bus.oNCE); end
        checks++; if (bus.oNWRT !== 1'b1) begin failures++; $display("FAIL rst_nwrt got=%b exp=1", bus.oNWRT); end
        checks++; if (bus.oRA !== 11'd0) begin failures++; $display("FAIL rst_ra got=%h exp=0", bus.oRA); end
        checks++; if (bus.oCA !== 4'd0) begin failures++; $display("FAIL rst_ca got=%h exp=0", bus.oCA); end
        checks++; if (bus.oDIN !== 64'd0) begin failures++; $display("FAIL rst_din got=%h exp=0", bus.oDIN); end
        checks++; if (bus.oRdDataValid !== 1'b0) begin failures++; $display("FAIL rst_rdvalid got=%b exp=0", bus.oRdDataValid); end
        checks++; if (bus.oRdData !== 64'd0) begin failures++; $display("FAIL rst_rddata got=%h exp=0", bus.oRdData); end
        checks++; if (bus.oWrReady !== 1'b0) begin failures++; $display("FAIL rst_wrready got=%b exp=0", bus.oWrReady); end
        checks++; if (bus.oRdReady !== 1'b0) begin failures++; $display("FAIL rst_rdready got=%b exp=0", bus.oRdReady); end
        @(posedge iClk); #1;
    endtask

    task automatic test_write_only();
        int acc;
        bit ok;
        int r;
        do_reset();
        r = cyc;
        for (int i = 0; i < 4; i++) begin
            wr_beat(AW'(16 + i), DW'(160 + i), acc, ok);
            checks++;
            if (!ok || acc != r + 1 + i) begin
                failures++;
                $display("FAIL wr_accept beat=%0d got=%0d exp=%0d", i, acc, r + 1 + i);
            end
        end
        bus.iWrValid = 1'b0;
        @(negedge iClk);
        checks++;
        if ({bus.oNCE, bus.oNWRT, bus.oRA, bus.oCA, bus.oDIN} !== {1'b0, 1'b0, 11'h001, 4'h3, 64'hA3}) begin
            failures++;
            $display("FAIL wr_last_pins got=%b%b %h %h %h exp=00 001 3 a3",
                     bus.oNCE, bus.oNWRT, bus.oRA, bus.oCA, bus.oDIN);
        end
        @(posedge iClk); #1;
        repeat (2) begin @(posedge iClk); #1; end
    endtask

    task automatic test_read_back();
        int acc;
        bit ok;
        int base;
        base = rd_seen;
        for (int i = 0; i < 4; i++) begin
            rd_beat(AW'(16 + i), acc, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL rd_accept beat=%0d got=timeout exp=accept", i); end
        end
        bus.iRdValid = 1'b0;
        for (int i = 0; i < 10 && rd_seen < base + 4; i++) begin @(posedge iClk); #1; end
        checks++;
        if (rd_seen != base + 4) begin
            failures++;
            $display("FAIL rd_count got=%0d exp=4", rd_seen - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd_log[base + i] !== DW'(160 + i)) begin
                    failures++;
                    $display("FAIL rd_back beat=%0d got=%h exp=%h", i, rd_log[base + i], DW'(160 + i));
                end
            end
        end
        drain();
    endtask

    task automatic test_alternate();
        int  wa;
        int  ra;
        bit  exp_w;
        bit  exp_r;
        logic acc_w;
        logic acc_r;
        do_reset();
        wa = 0;
        ra = 0;
        bus.iWrValid = 1'b1;
        bus.iRdValid = 1'b1;
        bus.iWrAddr  = AW'(256);
        bus.iWrData  = 64'hC0DE_0000_0000_0000;
        bus.iRdAddr  = AW'(256);
        for (int k = 0; k < 80; k++) begin
            @(negedge iClk);
            exp_w = (k > 0) && (((k - 1) / BL) % 2 == 0);
            exp_r = (k > 0) && !exp_w;
            checks++;
            if ({bus.oWrReady, bus.oRdReady} !== {exp_w, exp_r}) begin
                failures++;
                $display("FAIL alt_grant k=%0d got=%b%b exp=%b%b", k, bus.oWrReady, bus.oRdReady, exp_w, exp_r);
            end
            acc_w = bus.oWrReady;
            acc_r = bus.oRdReady;
            @(posedge iClk); #1;
            if (acc_w === 1'b1) begin
                wa++;
                bus.iWrAddr = AW'(256 + wa);
                bus.iWrData = 64'hC0DE_0000_0000_0000 | DW'(wa);
            end
            if (acc_r === 1'b1) begin
                ra++;
                bus.iRdAddr = AW'(256 + ra);
            end
        end
        idle_inputs();
        drain();
    endtask

    task automatic test_switch();
        logic [1:0] exp_g;
        logic acc_w;
        logic acc_r;
        int wa;
        int ra;
        do_reset();
        wa = 0;
        ra = 0;
        bus.iWrValid = 1'b1;
        bus.iRdValid = 1'b1;
        bus.iWrAddr  = AW'(512);
        bus.iWrData  = 64'h5A5A_0000_0000_0000;
        bus.iRdAddr  = AW'(512);
        for (int k = 0; k < 10; k++) begin
            if (k == 5) bus.iWrValid = 1'b0;
            @(negedge iClk);
            exp_g = (k == 0) ? 2'b00 : (k <= 5) ? 2'b10 : 2'b01;
            checks++;
            if ({bus.oWrReady, bus.oRdReady} !== exp_g) begin
                failures++;
                $display("FAIL switch_grant k=%0d got=%b%b exp=%b", k, bus.oWrReady, bus.oRdReady, exp_g);
            end
            acc_w = bus.oWrReady & bus.iWrValid;
            acc_r = bus.oRdReady & bus.iRdValid;
            @(posedge iClk); #1;
            if (acc_w === 1'b1) begin
                wa++;
                bus.iWrAddr = AW'(512 + wa);
                bus.iWrData = 64'h5A5A_0000_0000_0000 | DW'(wa);
            end
            if (acc_r === 1'b1) begin
                ra++;
                bus.iRdAddr = AW'(512 + ra);
            end
        end
        idle_inputs();
        drain();
    endtask

    task automatic test_max_addr();
        int acc;
        bit ok;
        bit seen;
        wr_beat(15'h7FFF, 64'hFFFF_FFFF_FFFF_FFFF, acc, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL max_wr_accept got=timeout exp=accept"); end
        bus.iWrValid = 1'b0;
        @(negedge iClk);
        checks++;
        if ({bus.oNCE, bus.oNWRT, bus.oRA, bus.oCA} !== {1'b0, 1'b0, 11'h7FF, 4'hF}) begin
            failures++;
            $display("FAIL max_pins got=%b%b %h %h exp=00 7ff f", bus.oNCE, bus.oNWRT, bus.oRA, bus.oCA);
        end
        @(posedge iClk); #1;
        rd_beat(15'h7FFF, acc, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL max_rd_accept got=timeout exp=accept"); end
        bus.iRdValid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge iClk);
            if (bus.oRdDataValid === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (bus.oRdData !== 64'hFFFF_FFFF_FFFF_FFFF) begin
                    failures++;
                    $display("FAIL max_rd_data got=%h exp=ffffffffffffffff", bus.oRdData);
                end
            end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL max_rd_valid got=none exp=valid"); end
        @(posedge iClk); #1;
        drain();
    endtask

    task automatic test_reset_mid();
        int acc;
        bit ok;
        rd_beat(15'h0012, acc, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rstmid_accept got=timeout exp=accept"); end
        bus.iRdValid = 1'b0;
        iReset = 1'b0;
        @(posedge iClk); #1;
        iReset = 1'b1;
        @(negedge iClk);
        checks++;
        if ({bus.oNCE, bus.oNWRT, bus.oRA, bus.oCA, bus.oDIN, bus.oRdDataValid, bus.oRdData,
             bus.oWrReady, bus.oRdReady} !== {1'b1, 1'b1, 11'd0, 4'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL rstmid_outputs got=%b%b %h %h %h %b %h %b%b exp=11 0 0 0 0 0 00",
                     bus.oNCE, bus.oNWRT, bus.oRA, bus.oCA, bus.oDIN, bus.oRdDataValid, bus.oRdData,
                     bus.oWrReady, bus.oRdReady);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge iClk);
            checks++;
            if (bus.oRdDataValid !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_dropped i=%0d got=%b exp=0", i, bus.oRdDataValid);
            end
        end
        @(posedge iClk); #1;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_only();
        test_read_back();
        test_alternate();
        test_switch();
        test_max_addr();
        test_reset_mid();
        checks++;
        if (rd_q.size() != 0) begin
            failures++;
            $display("FAIL end_pending got=%0d exp=0", rd_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
